// File: rtl/adder_pkg.sv
// Shared opcode encoding and legal parameter ranges for the pipelined adder.
package adder_pkg;

    localparam int OP_W        = 2;
    localparam int WIDTH_MIN   = 2;
    localparam int WIDTH_MAX   = 32;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ACC = 2'd2,
        OP_CLR = 2'd3
    } op_e;

endpackage

// File: rtl/adder_core.sv
// Combinational datapath: result, carry/borrow and next accumulator value
// for one operand pair, with optional clamping on overflow/underflow.
module adder_core
    import adder_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] acc_sum;

    always_comb begin
        add_sum  = {1'b0, a} + {1'b0, b};
        acc_sum  = {1'b0, acc} + {1'b0, a};
        c        = '0;
        carry    = 1'b0;
        acc_next = acc;
        case (op_e'(op))
            OP_ADD: begin
                carry = add_sum[WIDTH];
                c     = (SATURATE && carry) ? '1 : add_sum[WIDTH-1:0];
            end
            OP_SUB: begin
                carry = (a < b);
                c     = (SATURATE && carry) ? '0 : (a - b);
            end
            // The clamped value is what the accumulator keeps.
            OP_ACC: begin
                carry    = acc_sum[WIDTH];
                c        = (SATURATE && carry) ? '1 : acc_sum[WIDTH-1:0];
                acc_next = c;
            end
            OP_CLR: begin
                c        = acc;
                carry    = 1'b0;
                acc_next = '0;
            end
            default: begin
                c        = '0;
                carry    = 1'b0;
                acc_next = acc;
            end
        endcase
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined adder/accumulator with valid/ready handshakes on both sides and
// a fixed LATENCY-stage result pipeline that stalls as a whole.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LATENCY  = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("adder_pipe: WIDTH out of range");
    end
    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("adder_pipe: LATENCY out of range");
    end

    logic               advance;
    logic               accept;
    logic [WIDTH-1:0]   core_c;
    logic               core_carry;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [LATENCY-1:0] valid_q, valid_d;
    logic [LATENCY-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]   c_q [LATENCY];
    logic [WIDTH-1:0]   c_d [LATENCY];

    adder_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .a        (a),
        .b        (b),
        .op       (op),
        .acc      (acc_q),
        .c        (core_c),
        .carry    (core_carry),
        .acc_next (acc_next)
    );

    assign out_valid = valid_q[LATENCY-1];
    assign c         = c_q[LATENCY-1];
    assign carry     = carry_q[LATENCY-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid && in_ready;

    // Accumulator moves at acceptance so back-to-back ACCs chain without hazard.
    always_comb begin
        acc_d   = acc_q;
        valid_d = valid_q;
        carry_d = carry_q;
        c_d     = c_q;
        if (accept) begin
            acc_d = acc_next;
        end
        if (advance) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                valid_d[i] = valid_q[i-1];
                carry_d[i] = carry_q[i-1];
                c_d[i]     = c_q[i-1];
            end
            valid_d[0] = accept;
            carry_d[0] = accept ? core_carry : 1'b0;
            c_d[0]     = accept ? core_c : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            valid_q <= '0;
            carry_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                c_q[i] <= '0;
            end
        end else begin
            acc_q   <= acc_d;
            valid_q <= valid_d;
            carry_q <= carry_d;
            c_q     <= c_d;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: a wrapping and a saturating instance share
// stimulus; expected results are queued at acceptance and compared on output.
module tb_adder_pipe;

    localparam int W    = 8;
    localparam int LAT  = 2;
    localparam int MAXV = (1 << W) - 1;

    typedef struct {
        int e;
        int c_w;
        int cy_w;
        int c_s;
        int cy_s;
    } exp_t;

    exp_t sb[$];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = '0;
    logic         out_ready = 1'b1;

    logic         in_ready_w, out_valid_w, carry_w;
    logic [W-1:0] c_w;
    logic         in_ready_s, out_valid_s, carry_s;
    logic [W-1:0] c_s;

    int checks = 0;
    int errors = 0;
    int adv_edges = 0;
    int acc_w = 0;
    int acc_s = 0;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(W), .LATENCY(LAT), .SATURATE(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .c         (c_w),
        .carry     (carry_w)
    );

    adder_pipe #(.WIDTH(W), .LATENCY(LAT), .SATURATE(1'b1)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .c         (c_s),
        .carry     (carry_s)
    );

    task automatic compareVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic headReady();
        if (sb.size() == 0) return 1'b0;
        return (adv_edges >= sb[0].e + LAT - 1);
    endfunction

    task automatic checkOutput();
        logic exp_valid;
        if (!rst_n) begin
            compareVal("rst_out_valid_w", 32'(out_valid_w), 32'd0);
            compareVal("rst_c_w", 32'(c_w), 32'd0);
            compareVal("rst_carry_w", 32'(carry_w), 32'd0);
            compareVal("rst_in_ready_w", 32'(in_ready_w), 32'd1);
            compareVal("rst_out_valid_s", 32'(out_valid_s), 32'd0);
            compareVal("rst_in_ready_s", 32'(in_ready_s), 32'd1);
            return;
        end
        exp_valid = headReady();
        compareVal("out_valid_w", 32'(out_valid_w), 32'(exp_valid));
        compareVal("out_valid_s", 32'(out_valid_s), 32'(exp_valid));
        compareVal("in_ready_w", 32'(in_ready_w), 32'(!exp_valid || out_ready));
        compareVal("in_ready_s", 32'(in_ready_s), 32'(!exp_valid || out_ready));
        if (exp_valid) begin
            compareVal("c_wrap", 32'(c_w), 32'(sb[0].c_w));
            compareVal("carry_wrap", 32'(carry_w), 32'(sb[0].cy_w));
            compareVal("c_sat", 32'(c_s), 32'(sb[0].c_s));
            compareVal("carry_sat", 32'(carry_s), 32'(sb[0].cy_s));
        end
    endtask

    task automatic applyStimulus(input logic v, input int av, input int bv, input int opv,
                                 input logic ordy);
        logic exp_valid;
        logic adv;
        int   s;
        exp_t x;
        @(negedge clk);
        in_valid  = v;
        a         = av[W-1:0];
        b         = bv[W-1:0];
        op        = opv[1:0];
        out_ready = ordy;
        #1;
        checkOutput();
        if (rst_n) begin
            exp_valid = headReady();
            adv = !exp_valid || ordy;
            if (exp_valid && ordy) void'(sb.pop_front());
            if (adv) adv_edges++;
            if (v && adv) begin
                x.e = adv_edges;
                case (opv)
                    0: begin
                        s      = av + bv;
                        x.cy_w = (s > MAXV) ? 1 : 0;
                        x.c_w  = s & MAXV;
                        x.cy_s = x.cy_w;
                        x.c_s  = (x.cy_s != 0) ? MAXV : x.c_w;
                    end
                    1: begin
                        x.cy_w = (av < bv) ? 1 : 0;
                        x.c_w  = (av - bv) & MAXV;
                        x.cy_s = x.cy_w;
                        x.c_s  = (x.cy_s != 0) ? 0 : x.c_w;
                    end
                    2: begin
                        s      = acc_w + av;
                        x.cy_w = (s > MAXV) ? 1 : 0;
                        x.c_w  = s & MAXV;
                        acc_w  = x.c_w;
                        s      = acc_s + av;
                        x.cy_s = (s > MAXV) ? 1 : 0;
                        x.c_s  = (x.cy_s != 0) ? MAXV : s;
                        acc_s  = x.c_s;
                    end
                    default: begin
                        x.c_w  = acc_w;
                        x.cy_w = 0;
                        x.c_s  = acc_s;
                        x.cy_s = 0;
                        acc_w  = 0;
                        acc_s  = 0;
                    end
                endcase
                sb.push_back(x);
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 1'b1);
    endtask

    initial begin
        $display("[TB] reset hold with random inputs");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end
        #2 rst_n = 1'b1;

        $display("[TB] add and subtract");
        applyStimulus(1'b1, 200, 100, 0, 1'b1);
        applyStimulus(1'b1, 3, 4, 0, 1'b1);
        applyStimulus(1'b1, 5, 7, 1, 1'b1);
        applyStimulus(1'b1, 9, 9, 1, 1'b1);
        idle(3);

        $display("[TB] accumulate and clear");
        applyStimulus(1'b1, 10, 0, 2, 1'b1);
        applyStimulus(1'b1, 20, 0, 2, 1'b1);
        applyStimulus(1'b1, 30, 0, 2, 1'b1);
        applyStimulus(1'b1, 0, 0, 3, 1'b1);
        applyStimulus(1'b1, 1, 0, 2, 1'b1);
        applyStimulus(1'b1, 0, 0, 3, 1'b1);
        applyStimulus(1'b1, 250, 0, 2, 1'b1);
        applyStimulus(1'b1, 10, 0, 2, 1'b1);
        idle(3);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 1, 1, 0, 1'b1);
        applyStimulus(1'b1, 2, 2, 0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3, 3, 0, 1'b0);
        applyStimulus(1'b1, 3, 3, 0, 1'b1);
        applyStimulus(1'b1, 4, 4, 0, 1'b1);
        idle(4);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 0, 0, 3, 1'b1);
        applyStimulus(1'b1, 10, 0, 2, 1'b1);
        applyStimulus(1'b1, 20, 0, 2, 1'b1);
        applyStimulus(1'b1, 30, 0, 2, 1'b1);
        idle(3);
        applyStimulus(1'b1, 1, 0, 2, 1'b1);
        applyStimulus(1'b1, 2, 0, 2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        compareVal("pulse_out_valid_w", 32'(out_valid_w), 32'd0);
        compareVal("pulse_out_valid_s", 32'(out_valid_s), 32'd0);
        compareVal("pulse_c_w", 32'(c_w), 32'd0);
        compareVal("pulse_in_ready_w", 32'(in_ready_w), 32'd1);
        #1 rst_n = 1'b1;
        sb.delete();
        acc_w = 0;
        acc_s = 0;
        adv_edges = 0;
        applyStimulus(1'b1, 5, 0, 2, 1'b1);
        idle(4);

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0));
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined successor to the combinational `adder`. It accepts operand pairs over a valid/ready handshake and computes add, subtract, accumulate or accumulator-clear. Results come out after a configurable fixed latency, with a carry/borrow flag and optional saturation. It drops into the layered testbench in place of `adder`, driven through an extended interface by the generator and checked by the scoreboard.

## Interface
- `WIDTH`, 8, operand/result width in bits (2..32).
- `LATENCY`, 2, pipeline register stages from acceptance to output (1..4).
- `SATURATE`, 0, 1 = clamp results on overflow or underflow instead of wrapping.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand transaction present.
- `in_ready`  out  1  block can accept this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B (ignored for ACC and CLR).
- `op`  in  2  opcode: 0 ADD, 1 SUB, 2 ACC, 3 CLR.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `c`  out  WIDTH  result.
- `carry`  out  1  carry-out (ADD/ACC) or borrow (SUB); 0 for CLR.

## Operation
- Accept = `in_valid && in_ready` at a rising edge. Result and flag are computed combinationally from `a`, `b`, `op` and `acc`, then captured into stage 1.
- ADD: sum = a + b at WIDTH+1 bits.
  - `carry` = sum[WIDTH]; `c` = sum[WIDTH-1:0].
  - With SATURATE, `c` = all-ones when carry = 1.
- SUB: `c` = (a − b) mod 2^WIDTH; `carry` = (a < b).
  - With SATURATE, `c` = 0 when borrow = 1.
- ACC: internal WIDTH-bit `acc` ← acc + a, with ADD's carry and saturation rules.
  - `c` = the new acc value. The saturated value is what gets stored.
- CLR: `c` = the old acc value, `carry` = 0, then acc ← 0.
- `acc` changes only on an accepted ACC or CLR.
- Stage valid bits shift with the data. Bubbles are not collapsed.
- Stall: `advance = !out_valid || out_ready`. When advance = 0:
  - every stage holds;
  - `in_ready` = 0;
  - `c`, `carry` and `out_valid` stay stable.
- `in_ready = advance`. This is a combinational path from `out_ready` and is permitted.
- Results leave in acceptance order. No loss, no duplication.

## Timing
- Reset (`rst_n` low, asynchronous): all stage valids 0, stage data 0, `acc` 0.
  - `out_valid` 0, `c` 0, `carry` 0, `in_ready` 1.
  - This holds mid-stream: in-flight transactions are discarded, and no stale result appears after release.
- Latency: a transaction accepted at edge N, with no stall, shows `out_valid` = 1 and its result in the cycle after edge N+LATENCY−1.
  - With LATENCY = 1, the result is visible right after the accepting edge.
- A stall of k cycles adds k cycles to every transaction in flight.
- Throughput is one transaction per cycle while `out_ready` = 1.
- Back-to-back ACCs see each preceding accumulator update with no hazard, because `acc` updates at acceptance.
- Output handshake completes at an edge with `out_valid && out_ready`. The next stage's contents appear in the same edge.

## Structure
- `adder_pkg` holds:
  - the `op_e` enum (OP_ADD, OP_SUB, OP_ACC, OP_CLR);
  - opcode width constant 2;
  - the WIDTH and LATENCY legal-range constants, checked by elaboration assertions.
- Sub-module `adder_core`: combinational compute of {c, carry} from a, b, op, acc and SATURATE, and also the next acc.
- The top level owns `acc`, the stage array (valid, c, carry) and the handshake logic.
- `adder_if` is extended with `clk`, `rst_n` and the handshake signals. The generator drives `in_*`; the scoreboard models `acc` and the latency queue.

## Test plan
Default parameters: WIDTH = 8, LATENCY = 2.

1. Reset: hold `rst_n` = 0 with random inputs → `out_valid` = 0, `c` = 0, `carry` = 0, `in_ready` = 1 throughout.
2. ADD 200+100 at edge N → after edge N+1, `c` = 44, `carry` = 1.
   - With SATURATE = 1 → `c` = 255, `carry` = 1.
   - ADD 3+4 → `c` = 7, `carry` = 0.
3. SUB 5−7 → `c` = 254, `carry` = 1. With SATURATE = 1 → `c` = 0. SUB 9−9 → `c` = 0, `carry` = 0.
4. Back-to-back ACC with a = 10, 20, 30 → `c` = 10, 30, 60 on consecutive cycles.
   - Then CLR → `c` = 60, then ACC 1 → `c` = 1.
   - ACC 250 then 10 → `c` = 4 with `carry` = 1 (SATURATE = 0), or `c` = 255 (SATURATE = 1).
5. Backpressure: stream ADDs 1+1, 2+2, 3+3, 4+4 and drop `out_ready` for 3 cycles when the first result appears.
   - `c` holds 2 and `in_ready` = 0 during the stall.
   - Results 2, 4, 6, 8 then arrive in order, each exactly once.
6. Reset mid-stream: with `acc` = 60 and two ACCs in flight, pulse `rst_n` low between edges.
   - `out_valid` drops immediately.
   - After release, ACC 5 → `c` = 5 and no earlier result ever appears.
